// File: rtl/pll_cen_gen.sv
// -----------------------------------------------------------------------------
// pll_cen_gen
//   Multi-channel fractional clock-enable generator, gated by PLL lock.
//   Runs on the fast PLL output clock.
//   Each channel adds its step to a phase accumulator every cycle.
//   The carry out of that sum is registered as a one-cycle enable pulse.
//   Pulse rate: f_cen = f_refclk * step / 2^ACC_W.
//   Enables stay off until the synchronised lock has been high for LOCK_FILT
//   consecutive cycles. Step values can be retuned at runtime through a
//   valid/ready write port.
//
// Ports
//   i_refclk      fast clock
//   i_rst_n       asynchronous active-low reset
//   i_pll_locked  PLL lock, asynchronous to i_refclk
//   i_cfg_valid   step-write request
//   o_cfg_ready   step-write accept (high whenever out of reset)
//   i_cfg_chan    target channel of the write
//   i_cfg_step    new step value
//   i_cfg_phrst   1 = also clear the target accumulator on the write
//   o_ready       enables running (state RUN)
//   o_cen         one-cycle clock-enable pulses, one per channel
//   o_drop_cnt    count of lock losses while in RUN, saturates at 255
// -----------------------------------------------------------------------------
module pll_cen_gen #(
    parameter int                        CHANNELS     = 3,
    parameter int                        ACC_W        = 32,
    parameter int                        LOCK_FILT    = 1024,
    parameter int                        SYNC_STAGES  = 2,
    parameter logic [CHANNELS*ACC_W-1:0] DEFAULT_STEP = {CHANNELS{ACC_W'(32'h15555555)}},
    localparam int                       CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_refclk,
    input  logic                i_rst_n,
    input  logic                i_pll_locked,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [CHAN_W-1:0]   i_cfg_chan,
    input  logic [ACC_W-1:0]    i_cfg_step,
    input  logic                i_cfg_phrst,
    output logic                o_ready,
    output logic [CHANNELS-1:0] o_cen,
    output logic [7:0]          o_drop_cnt
);

    localparam int CNT_W = (LOCK_FILT > 2) ? $clog2(LOCK_FILT) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_filt_cnt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_ready;
    logic                     r_cfg_ready;
    logic [7:0]               r_drop_cnt;
    logic                     w_lk;
    logic                     w_run_stay;
    logic                     w_wr;

    // Lock synchroniser; only its last stage is used anywhere downstream.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_locked};
        end
    end

    assign w_lk = r_sync[SYNC_STAGES-1];

    // Accumulators only advance while RUN persists into the next cycle.
    // This clears them both on RUN entry and on lock loss.
    assign w_run_stay = (r_state == RUN) && w_lk;
    assign w_wr       = i_cfg_valid && r_cfg_ready;

    // Lock-filter FSM with registered ready and drop counter.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= WAIT_LOCK;
            r_filt_cnt  <= '0;
            r_ready     <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_cfg_ready <= 1'b1;
            case (r_state)
                WAIT_LOCK: begin
                    r_ready <= 1'b0;
                    if (w_lk) begin
                        r_state    <= STABILISE;
                        r_filt_cnt <= '0;
                    end
                end
                STABILISE: begin
                    if (!w_lk) begin
                        r_state <= WAIT_LOCK;
                        r_ready <= 1'b0;
                    end else if (r_filt_cnt == CNT_W'(LOCK_FILT - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_filt_cnt <= r_filt_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!w_lk) begin
                        r_state <= WAIT_LOCK;
                        r_ready <= 1'b0;
                        if (r_drop_cnt != 8'hFF) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= WAIT_LOCK;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel step register, phase accumulator and enable flop.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [ACC_W-1:0] r_step;
            logic [ACC_W-1:0] r_acc;
            logic             r_cen;
            logic [ACC_W:0]   w_sum;
            logic             w_hit;

            assign w_sum = {1'b0, r_acc} + {1'b0, r_step};
            // Out-of-range channel numbers match nothing, so they are silently absorbed.
            assign w_hit = w_wr && (i_cfg_chan == CHAN_W'(gi));

            always_ff @(posedge i_refclk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_step <= DEFAULT_STEP[gi*ACC_W +: ACC_W];
                    r_acc  <= '0;
                    r_cen  <= 1'b0;
                end else begin
                    // The step update always lands, even when a lock loss clears the accumulator.
                    if (w_hit) begin
                        r_step <= i_cfg_step;
                    end
                    if (!w_run_stay || (w_hit && i_cfg_phrst)) begin
                        r_acc <= '0;
                        r_cen <= 1'b0;
                    end else begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_cen <= w_sum[ACC_W];
                    end
                end
            end

            assign o_cen[gi] = r_cen;
        end
    endgenerate

    assign o_ready     = r_ready;
    assign o_cfg_ready = r_cfg_ready;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pll_cen_gen.sv
module tb_pll_cen_gen;

    localparam int CH = 3;

    logic        refclk;
    logic        rst_n;
    logic        pll_locked;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [31:0] cfg_step;
    logic        cfg_phrst;
    logic        ready;
    logic [2:0]  cen;
    logic [7:0]  drop_cnt;

    pll_cen_gen #(
        .CHANNELS    (CH),
        .ACC_W       (32),
        .LOCK_FILT   (16),
        .SYNC_STAGES (2)
    ) dut (
        .i_refclk     (refclk),
        .i_rst_n      (rst_n),
        .i_pll_locked (pll_locked),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_chan   (cfg_chan),
        .i_cfg_step   (cfg_step),
        .i_cfg_phrst  (cfg_phrst),
        .o_ready      (ready),
        .o_cen        (cen),
        .o_drop_cnt   (drop_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int n_vec;
    int n_err;

    typedef struct {
        logic [1:0]  chan;
        logic [31:0] step;
        int          exp_first;   // edges after the write edge; 0 = no pulse in window
        int          exp_cnt;     // pulses within 48 edges after the write
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("  ok  %s = %0d", name, act);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic relock(output int edges, output int cen_seen);
        pll_locked = 1'b1;
        edges      = -1;
        cen_seen   = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (cen != 3'b000) cen_seen++;
            if (ready) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic drop(output int edges);
        pll_locked = 1'b0;
        edges      = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (!ready && cen == 3'b000) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [31:0] st, input logic ph);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_step  = st;
        cfg_phrst = ph;
        tick();
        cfg_valid = 1'b0;
        cfg_phrst = 1'b0;
    endtask

    initial begin
        int e, c, cnt, first, neq, bad;

        vt[0] = '{2'd0, 32'h80000000,  2, 24};
        vt[1] = '{2'd1, 32'h40000000,  4, 12};
        vt[2] = '{2'd2, 32'h00000000,  0,  0};
        vt[3] = '{2'd0, 32'hFFFFFFFF,  2, 47};
        vt[4] = '{2'd1, 32'h15555555, 13,  3};
        vt[5] = '{2'd2, 32'h30000000,  6,  9};
        vt[6] = '{2'd0, 32'h00000001,  0,  0};

        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        cfg_valid  = 1'b0;
        cfg_chan   = 2'd0;
        cfg_step   = 32'd0;
        cfg_phrst  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", ready, 0);
        chk("rst_cen", cen, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("cfg_ready_after_rst", cfg_ready, 1);

        // T2 glitch: 10 cycles high, 1 low, then high; filter must restart
        pll_locked = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (ready) bad++;
        end
        pll_locked = 1'b0;
        tick();
        if (ready) bad++;
        chk("t2_no_ready_before_glitch_end", bad, 0);
        relock(e, c);
        chk("t2_relock_edges_in_18pm1", (e >= 17 && e <= 19) ? 1 : 0, 1);
        chk("t2_cen_during_lock", c, 0);
        chk("t2_drop_cnt", drop_cnt, 0);

        // T1 clean lock filter after reset
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        relock(e, c);
        chk("t1_lock_edges_in_18pm1", (e >= 17 && e <= 19) ? 1 : 0, 1);
        chk("t1_cen_during_lock", c, 0);

        // T3 default rate: 99 pulses in 1200 RUN cycles, 100th on cycle 1201
        cnt = 0; neq = 0; first = 0;
        for (int n = 1; n <= 1200; n++) begin
            tick();
            if (cen[0]) begin
                cnt++;
                if (first == 0) first = n;
            end
            if (cen != 3'b000 && cen != 3'b111) neq++;
        end
        chk("t3_first_pulse_cycle", first, 13);
        chk("t3_pulses_in_1200", cnt, 99);
        chk("t3_channels_aligned", neq, 0);
        tick();
        chk("t3_pulse_at_1201", cen, 3'b111);

        // T4 retune ch1 to half rate with phase reset
        write(2'd1, 32'h80000000, 1'b1);
        chk("t4_cen1_on_write_edge", cen[1], 0);
        bad = 0; neq = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (cen[1] !== ((n % 2) == 0)) bad++;
            if (cen[0] !== cen[2]) neq++;
        end
        chk("t4_ch1_half_rate_errors", bad, 0);
        chk("t4_ch0_ch2_diverged", neq, 0);

        // Table-driven retunes, each with phase reset
        for (int v = 0; v < 7; v++) begin
            chk($sformatf("v%0d_cfg_ready", v), cfg_ready, 1);
            write(vt[v].chan, vt[v].step, 1'b1);
            cnt = 0; first = 0;
            for (int n = 1; n <= 48; n++) begin
                tick();
                if (cen[vt[v].chan]) begin
                    cnt++;
                    if (first == 0) first = n;
                end
            end
            chk($sformatf("v%0d_ch%0d_step%08h_first", v, vt[v].chan, vt[v].step),
                first, vt[v].exp_first);
            chk($sformatf("v%0d_ch%0d_step%08h_count", v, vt[v].chan, vt[v].step),
                cnt, vt[v].exp_cnt);
        end

        // T5 lock loss in RUN
        drop(e);
        chk("t5_loss_edges_le3", (e >= 1 && e <= 3) ? 1 : 0, 1);
        chk("t5_drop_cnt_1", drop_cnt, 1);
        bad = 0;
        for (int i = 2; i <= 300; i++) begin
            relock(e, c);
            if (e < 0) bad++;
            drop(e);
            if (e < 0) bad++;
        end
        chk("t5_loop_timeouts", bad, 0);
        chk("t5_drop_cnt_saturated", drop_cnt, 255);

        // T6 async reset mid-RUN after a retune
        relock(e, c);
        chk("t6_relock_edges", (e >= 17 && e <= 19) ? 1 : 0, 1);
        write(2'd1, 32'h80000000, 1'b1);
        tick();
        tick();
        chk("t6_ch1_retuned_pulse", cen[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_ready", ready, 0);
        chk("t6_async_cen", cen, 0);
        chk("t6_async_drop_cnt", drop_cnt, 0);
        chk("t6_async_cfg_ready", cfg_ready, 0);
        pll_locked = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        relock(e, c);
        chk("t6_relock_after_rst", (e >= 17 && e <= 19) ? 1 : 0, 1);
        // Out-of-range channel write: accepted, no effect on any channel
        write(2'd3, 32'h80000000, 1'b1);
        bad = 0;
        for (int n = 1; n <= 13; n++) begin
            if (n > 1) tick();
            if (n < 13 && cen != 3'b000) bad++;
        end
        chk("t6_no_early_pulse", bad, 0);
        chk("t6_default_rate_pulse_13", cen, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
